// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM encoding for the instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default address width, default index width, instruction word
// size and the two-state miss FSM encoding.
package inst_cache_pkg;

  localparam int ICACHE_ADDR_W = 32;  // instruction address width
  localparam int ICACHE_IDX_W  = 8;   // 2**IDX_W one-word lines
  localparam int INSTR_SIZE    = 32;  // instruction word width

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // accepting requests, hits answered next cycle
    ST_MISS = 1'b1    // one word outstanding at the memory controller
  } icache_state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Tag and data storage for the direct-mapped instruction cache.
// Latency: read is combinational; a write lands at the clock edge.
// Backpressure: none; the caller gates the write enable.
//
// Ports:
//   i_clk               clock
//   i_rd_idx            line index to read
//   o_rd_tag/o_rd_data  stored tag and word of that line
//   i_wr_en             write one line this edge
//   i_wr_idx/i_wr_tag/i_wr_data  line index, tag and word to write
// Storage is not reset: the valid vector kept by the parent decides whether
// a line's contents mean anything.
module inst_cache_array #(
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 22,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_tag  = r_tag[i_rd_idx];
  assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-line instruction cache between IF and the memory controller.
// Latency: hit answered 1 cycle after the request; a miss answers 1 cycle after the matching mem_done.
// Backpressure: i_pause freezes all state and outputs; a miss holds o_mem_req_flag until its word returns.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pause                 freeze everything (outputs hold, mem_done ignored)
//   i_invalidate            clear every valid bit this edge
//   i_req_flag/i_req_addr   IF fetch request
//   o_instruction_flag      one-cycle response pulse
//   o_instruction_read_address, o_instruction   address and word of the response
//   o_mem_req_flag/o_mem_req_addr   miss fetch request to the memory controller
//   i_mem_done/i_mem_addr/i_mem_data  word fetch completion from the memory controller
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int ADDR_W = ICACHE_ADDR_W,
  parameter int IDX_W  = ICACHE_IDX_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pause,
  input  logic                  i_invalidate,
  input  logic                  i_req_flag,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  o_instruction_flag,
  output logic [ADDR_W-1:0]     o_instruction_read_address,
  output logic [INSTR_SIZE-1:0] o_instruction,
  output logic                  o_mem_req_flag,
  output logic [ADDR_W-1:0]     o_mem_req_addr,
  input  logic                  i_mem_done,
  input  logic [ADDR_W-1:0]     i_mem_addr,
  input  logic [INSTR_SIZE-1:0] i_mem_data
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int LINES = 1 << IDX_W;

  icache_state_t r_state, w_state_nxt;

  logic [LINES-1:0]      r_valid;
  logic [ADDR_W-1:0]     r_miss_addr;
  logic                  r_mem_req;
  logic                  r_inst_flag;
  logic [ADDR_W-1:0]     r_inst_addr;
  logic [INSTR_SIZE-1:0] r_inst;

  logic [IDX_W-1:0]      w_req_idx, w_miss_idx;
  logic [TAG_W-1:0]      w_req_tag, w_miss_tag, w_rd_tag;
  logic [INSTR_SIZE-1:0] w_rd_data;
  logic                  w_hit;
  logic                  w_fill_match;

  logic                  w_resp_vld;
  logic [ADDR_W-1:0]     w_resp_addr;
  logic [INSTR_SIZE-1:0] w_resp_dat;
  logic                  w_fill_en;
  logic                  w_latch_miss;
  logic                  w_mem_req_nxt;

  assign w_req_idx  = i_req_addr[IDX_W+1:2];
  assign w_req_tag  = i_req_addr[ADDR_W-1:IDX_W+2];
  assign w_miss_idx = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag = r_miss_addr[ADDR_W-1:IDX_W+2];

  inst_cache_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (INSTR_SIZE)
  ) u_array (
    .i_clk     (i_clk),
    .i_rd_idx  (w_req_idx),
    .o_rd_tag  (w_rd_tag),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_fill_en && !i_pause),
    .i_wr_idx  (w_miss_idx),
    .i_wr_tag  (w_miss_tag),
    .i_wr_data (i_mem_data)
  );

  // A same-cycle invalidate turns a would-be hit into a miss, so the
  // request is refetched rather than served from a line about to be dropped.
  assign w_hit = r_valid[w_req_idx] && (w_rd_tag == w_req_tag) && !i_invalidate;

  // Only the completion for our own outstanding address ends the miss.
  assign w_fill_match = (r_state == ST_MISS) && i_mem_done && (i_mem_addr == r_miss_addr);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (!i_pause) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_req_flag && !w_hit) w_state_nxt = ST_MISS;
      ST_MISS: if (w_fill_match)         w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    w_resp_vld    = 1'b0;
    w_resp_addr   = i_req_addr;
    w_resp_dat    = w_rd_data;
    w_fill_en     = 1'b0;
    w_latch_miss  = 1'b0;
    w_mem_req_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_flag) begin
          if (w_hit) begin
            w_resp_vld = 1'b1;
          end else begin
            w_latch_miss  = 1'b1;
            w_mem_req_nxt = 1'b1;
          end
        end
      end
      ST_MISS: begin
        w_mem_req_nxt = !w_fill_match;
        w_fill_en     = w_fill_match;
        w_resp_addr   = r_miss_addr;
        w_resp_dat    = i_mem_data;
        // A redirected request still gets its line filled but no pulse.
        w_resp_vld    = w_fill_match && i_req_flag && (i_req_addr == r_miss_addr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= '0;
      r_miss_addr <= '0;
      r_mem_req   <= 1'b0;
      r_inst_flag <= 1'b0;
      r_inst_addr <= '0;
      r_inst      <= '0;
    end else if (!i_pause) begin
      // Invalidate beats a same-edge fill: the data is written but the line stays invalid.
      if (i_invalidate) begin
        r_valid <= '0;
      end else if (w_fill_en) begin
        r_valid[w_miss_idx] <= 1'b1;
      end
      if (w_latch_miss) begin
        r_miss_addr <= i_req_addr;
      end
      r_mem_req   <= w_mem_req_nxt;
      r_inst_flag <= w_resp_vld;
      if (w_resp_vld) begin
        r_inst_addr <= w_resp_addr;
        r_inst      <= w_resp_dat;
      end
    end
  end

  assign o_instruction_flag         = r_inst_flag;
  assign o_instruction_read_address = r_inst_addr;
  assign o_instruction              = r_inst;
  assign o_mem_req_flag             = r_mem_req;
  assign o_mem_req_addr             = r_miss_addr;

endmodule

// File: tb/tb_inst_cache.sv
// Directed testbench for inst_cache.
// Latency: n/a.
// Backpressure: n/a.
module tb_inst_cache;

  logic        clk;
  logic        rst_n;
  logic        pause;
  logic        invalidate;
  logic        req_flag;
  logic [31:0] req_addr;
  logic        inst_flag;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_req_addr;
  logic        mem_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_errors = 0;

  inst_cache dut (
    .i_clk                      (clk),
    .i_rst_n                    (rst_n),
    .i_pause                    (pause),
    .i_invalidate               (invalidate),
    .i_req_flag                 (req_flag),
    .i_req_addr                 (req_addr),
    .o_instruction_flag         (inst_flag),
    .o_instruction_read_address (inst_addr),
    .o_instruction              (inst),
    .o_mem_req_flag             (mem_req),
    .o_mem_req_addr             (mem_req_addr),
    .i_mem_done                 (mem_done),
    .i_mem_addr                 (mem_addr),
    .i_mem_data                 (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a cold line, return its word two cycles later, expect one pulse.
  task automatic fetch_miss(input logic [31:0] a, input logic [31:0] d);
    req_flag = 1'b1;
    req_addr = a;
    tick();
    chk("miss_req",     mem_req, 1);
    chk("miss_reqaddr", mem_req_addr, a);
    chk("miss_noflag",  inst_flag, 0);
    tick();
    chk("miss_hold",    mem_req, 1);
    mem_done = 1'b1;
    mem_addr = a;
    mem_data = d;
    tick();
    mem_done = 1'b0;
    req_flag = 1'b0;
    chk("fill_flag",    inst_flag, 1);
    chk("fill_data",    inst, d);
    chk("fill_addr",    inst_addr, a);
    chk("fill_reqdrop", mem_req, 0);
    tick();
    chk("fill_pulse",   inst_flag, 0);
  endtask

  // Request a resident line, expect the answer next cycle with no memory traffic.
  task automatic fetch_hit(input logic [31:0] a, input logic [31:0] d);
    req_flag = 1'b1;
    req_addr = a;
    tick();
    chk("hit_flag",  inst_flag, 1);
    chk("hit_data",  inst, d);
    chk("hit_addr",  inst_addr, a);
    chk("hit_nomem", mem_req, 0);
    req_flag = 1'b0;
    tick();
    chk("hit_pulse", inst_flag, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pause      = 1'b0;
    invalidate = 1'b0;
    req_flag   = 1'b0;
    req_addr   = '0;
    mem_done   = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    #23;
    chk("rst_flag",    inst_flag, 0);
    chk("rst_memreq",  mem_req, 0);
    chk("rst_memaddr", mem_req_addr, 0);
    chk("rst_inst",    inst, 0);
    chk("rst_iaddr",   inst_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Cold miss, then hit on the same address.
    fetch_miss(32'h0000_0100, 32'h0000_0513);
    fetch_hit(32'h0000_0100, 32'h0000_0513);

    // Conflict: 0x500 shares the index of 0x100.
    fetch_miss(32'h0000_0500, 32'hAAAA_0001);
    fetch_hit(32'h0000_0500, 32'hAAAA_0001);

    // 0x100 was evicted; a completion for a different address must not end the miss.
    req_flag = 1'b1;
    req_addr = 32'h0000_0100;
    tick();
    chk("evict_miss", mem_req, 1);
    mem_done = 1'b1;
    mem_addr = 32'h0000_0104;
    mem_data = 32'hDEAD_BEEF;
    tick();
    chk("wrongdone_req",  mem_req, 1);
    chk("wrongdone_flag", inst_flag, 0);
    mem_addr = 32'h0000_0100;
    mem_data = 32'h0000_0513;
    tick();
    mem_done = 1'b0;
    req_flag = 1'b0;
    chk("refill_flag", inst_flag, 1);
    chk("refill_data", inst, 32'h0000_0513);
    tick();

    // Redirect: miss on 0x200, IF moves to 0x300 before the word returns.
    req_flag = 1'b1;
    req_addr = 32'h0000_0200;
    tick();
    chk("redir_req",  mem_req, 1);
    chk("redir_addr", mem_req_addr, 32'h0000_0200);
    req_addr = 32'h0000_0300;
    tick();
    chk("redir_hold", mem_req, 1);
    chk("redir_addr_stable", mem_req_addr, 32'h0000_0200);
    mem_done = 1'b1;
    mem_addr = 32'h0000_0200;
    mem_data = 32'h0000_2222;
    tick();
    mem_done = 1'b0;
    chk("redir_noflag", inst_flag, 0);
    chk("redir_drop",   mem_req, 0);
    tick();
    chk("redir_new_req",  mem_req, 1);
    chk("redir_new_addr", mem_req_addr, 32'h0000_0300);
    mem_done = 1'b1;
    mem_addr = 32'h0000_0300;
    mem_data = 32'h0000_3333;
    tick();
    mem_done = 1'b0;
    req_flag = 1'b0;
    chk("redir_new_flag", inst_flag, 1);
    chk("redir_new_data", inst, 32'h0000_3333);
    tick();
    fetch_hit(32'h0000_0200, 32'h0000_2222);

    // Back-to-back hits on two resident lines.
    req_flag = 1'b1;
    req_addr = 32'h0000_0200;
    tick();
    req_addr = 32'h0000_0300;
    chk("b2b_flag0", inst_flag, 1);
    chk("b2b_data0", inst, 32'h0000_2222);
    tick();
    req_flag = 1'b0;
    chk("b2b_flag1", inst_flag, 1);
    chk("b2b_data1", inst, 32'h0000_3333);
    tick();

    // Invalidate pulse drops 0x100.
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    fetch_miss(32'h0000_0100, 32'h0000_0513);

    // Invalidate coincident with a fill: pulse fires, line stays invalid.
    req_flag = 1'b1;
    req_addr = 32'h0000_0600;
    tick();
    tick();
    mem_done   = 1'b1;
    mem_addr   = 32'h0000_0600;
    mem_data   = 32'h0000_6666;
    invalidate = 1'b1;
    tick();
    mem_done   = 1'b0;
    invalidate = 1'b0;
    req_flag   = 1'b0;
    chk("invfill_flag", inst_flag, 1);
    chk("invfill_data", inst, 32'h0000_6666);
    tick();
    fetch_miss(32'h0000_0600, 32'h0000_6666);

    // 0x600 is resident now, but a same-cycle invalidate makes it a miss.
    req_flag   = 1'b1;
    req_addr   = 32'h0000_0600;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    chk("invhit_miss",   mem_req, 1);
    chk("invhit_noflag", inst_flag, 0);
    mem_done = 1'b1;
    mem_addr = 32'h0000_0600;
    mem_data = 32'h0000_6666;
    tick();
    mem_done = 1'b0;
    req_flag = 1'b0;
    chk("invhit_fill", inst_flag, 1);
    tick();

    // Reset in the middle of a miss drops the request immediately.
    req_flag = 1'b1;
    req_addr = 32'h0000_0700;
    tick();
    chk("rstmiss_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmiss_async", mem_req, 0);
    req_flag = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mem_done = 1'b1;
    mem_addr = 32'h0000_0700;
    mem_data = 32'h0000_7777;
    tick();
    mem_done = 1'b0;
    chk("stray_flag", inst_flag, 0);
    chk("stray_req",  mem_req, 0);
    tick();

    // Reset cleared the valid bits: 0x100 misses again, then pause around a hit.
    fetch_miss(32'h0000_0100, 32'h0000_0513);
    req_flag = 1'b1;
    req_addr = 32'h0000_0100;
    pause    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_noflag", inst_flag, 0);
    end
    pause = 1'b0;
    tick();
    req_flag = 1'b0;
    chk("pause_flag", inst_flag, 1);
    chk("pause_data", inst, 32'h0000_0513);
    tick();
    chk("pause_pulse", inst_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
